// File: rtl/bus_pkg.sv
// Shared widths and arbiter state encoding for the memory bus arbiter.
package bus_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } arb_state_e;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_picker #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic             valid
);
  int idx;

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    winner = '0;
    valid  = |req;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin shared-memory arbiter with fixed read latency and locked bursts.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int LATENCY   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_read,
  output logic                   mem_write,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   busy
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int BW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [NREQ-1:0]   pick;
  logic              pick_vld;
  logic [PTR_W-1:0]  gidx;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              in_access;

  rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick),
    .valid  (pick_vld)
  );

  // Only the granted requester's fields reach the bus.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_q[i]) gidx = PTR_W'(i);
    g_we    = we[gidx];
    g_addr  = addr[gidx*ADDR_W +: ADDR_W];
    g_wdata = wdata[gidx*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    wcnt_d  = wcnt_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rd_d    = ~g_we;
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (int'(wcnt_q) == LATENCY - 1) begin
          if (rd_q) rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        if (lock[gidx] && req[gidx] && int'(burst_q) < MAX_BURST - 1) begin
          burst_d = burst_q + 1'b1;
          state_d = ST_ACCESS;
        end else begin
          burst_d = '0;
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      wcnt_q  <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      wcnt_q  <= wcnt_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign gnt       = gnt_q;
  assign ack       = (state_q == ST_DONE) ? gnt_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign rdata     = rdata_q;
  assign mem_read  = in_access & ~g_we;
  assign mem_write = in_access & g_we;
  assign mem_addr  = in_access ? g_addr  : '0;
  assign mem_wdata = in_access ? g_wdata : '0;
endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed checks of bus_arbiter against a transaction-level model.
module tb_bus_arbiter;
  localparam int N  = 3;
  localparam int L  = 1;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, lock, we;
  logic [N*16-1:0] addr, wdata;
  logic [N-1:0]   gnt, ack;
  logic [15:0]    rdata, mem_addr, mem_wdata, mem_rdata;
  logic           mem_read, mem_write, busy;

  int n_cmp = 0;
  int n_bad = 0;

  bus_arbiter #(.NREQ(N), .LATENCY(L), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: an access occupies phases t = 0 (strobe) .. L (waits) .. L+1 (ack).
  bit          m_busy  = 0;
  bit          m_rd    = 0;
  int          m_g     = 0;
  int          m_t     = 0;
  int          m_burst = 0;
  int          m_ptr   = 0;
  logic [15:0] m_rdata = '0;
  int          starve [N];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 0; m_rd <= 0; m_g <= 0; m_t <= 0;
      m_burst <= 0; m_ptr <= 0; m_rdata <= '0;
    end else if (!m_busy) begin
      if (|req) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_ptr + k) % N]) m_g <= (m_ptr + k) % N;
        m_busy <= 1;
        m_t    <= 0;
      end
    end else if (m_t <= L) begin
      if (m_t == 0) m_rd <= !we[m_g];
      if (m_t == L && m_rd) m_rdata <= mem_rdata;
      m_t <= m_t + 1;
    end else begin
      m_ptr <= (m_g + 1) % N;
      if (lock[m_g] && req[m_g] && m_burst < MB - 1) begin
        m_burst <= m_burst + 1;
        m_t     <= 0;
      end else begin
        m_busy  <= 0;
        m_burst <= 0;
      end
    end
  end

  // Completed accesses seen by each requester while it keeps asking.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!reset || !req[i] || (m_busy && m_g == i)) starve[i] <= 0;
      else if (m_busy && m_t == L + 1)             starve[i] <= starve[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eg, ea;
    logic         acc;
    eg  = '0;
    ea  = '0;
    if (m_busy) eg[m_g] = 1'b1;
    if (m_busy && m_t == L + 1) ea = eg;
    acc = m_busy && m_t == 0;
    chk("gnt", gnt, eg);
    chk("ack", ack, ea);
    chk("busy", busy, m_busy);
    chk("mem_read", mem_read, acc && !we[m_g]);
    chk("mem_write", mem_write, acc && we[m_g]);
    chk("mem_addr", mem_addr, acc ? addr[m_g*16 +: 16] : 16'h0);
    chk("mem_wdata", mem_wdata, acc ? wdata[m_g*16 +: 16] : 16'h0);
    chk("rdata", rdata, m_rdata);
    for (int i = 0; i < N; i++) chk("starve", starve[i] <= N * MB, 1);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0; lock = '0; we = '0;
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  task automatic drain();
    req = '0; lock = '0;
    for (int c = 0; c < 20 && busy; c++) cyc();
    cyc();
    chk("drain_idle", busy, 0);
  endtask

  initial begin
    logic [N-1:0] prev;
    int order[$];
    int exp036[4];
    logic [N-1:0] acks[$];
    int n_ack, n_wr;

    reset = 1'b0; req = '0; lock = '0; we = '0;
    addr = '0; wdata = '0; mem_rdata = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rdata", rdata, 0);
    do_reset();

    // CPU single read
    req = 3'b001; we = 3'b000; addr[15:0] = 16'h0123; mem_rdata = 16'hBEEF;
    cyc();
    chk("cpu_rd_strobe", mem_read, 1);
    chk("cpu_rd_addr", mem_addr, 16'h0123);
    cyc();
    cyc();
    chk("cpu_ack", ack, 3'b001);
    chk("cpu_rdata", rdata, 16'hBEEF);
    req = '0;

    // DMA write leaves rdata alone
    cyc();
    req = 3'b100; we = 3'b100; addr[47:32] = 16'h7FF0; wdata[47:32] = 16'h5A5A;
    mem_rdata = 16'h1111;
    n_wr = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (mem_write) begin
        n_wr++;
        chk("dma_addr", mem_addr, 16'h7FF0);
        chk("dma_wdata", mem_wdata, 16'h5A5A);
      end
      if (ack[2]) req = '0;
    end
    chk("dma_wr_count", n_wr, 1);
    chk("dma_rdata_kept", rdata, 16'hBEEF);
    we = '0;
    drain();

    // Round robin with everyone requesting
    do_reset();
    req = 3'b111;
    exp036 = '{0, 1, 2, 0};
    prev = '0;
    for (int c = 0; c < 30 && order.size() < 4; c++) begin
      cyc();
      if (gnt != 0 && gnt != prev) order.push_back($clog2(gnt));
      prev = gnt;
    end
    chk("rr_len", order.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("rr_order", (k < order.size()) ? order[k] : -1, exp036[k]);
    drain();

    // GPU locked burst then CPU
    do_reset();
    req = 3'b010; lock = 3'b010;
    cyc();
    req = 3'b011;
    for (int c = 0; c < 60 && acks.size() < 5; c++) begin
      cyc();
      if (ack != 0) acks.push_back(ack);
    end
    chk("burst_len", acks.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("burst_ack", (k < acks.size()) ? acks[k] : 3'b000, (k < 4) ? 3'b010 : 3'b001);
    drain();

    // Reset during WAIT
    do_reset();
    req = 3'b001;
    cyc();
    cyc();
    chk("pre_rst_wait", busy, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_gnt", gnt, 0);
    chk("rst_mid_ack", ack, 0);
    check_all();
    req = 3'b110;
    cyc();
    reset = 1'b1;
    cyc();
    chk("post_rst_gnt", gnt, 3'b010);
    drain();

    // CPU drops req right after grant
    do_reset();
    req = 3'b001;
    cyc();
    chk("drop_gnt", gnt, 3'b001);
    req = '0;
    n_ack = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (ack[0]) n_ack++;
    end
    chk("drop_ack_once", n_ack, 1);
    chk("drop_idle", busy, 0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      cyc();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(255) == 0) begin
        reset = 1'b0;
        #1;
        check_all();
      end
      req       = N'($urandom);
      lock      = N'($urandom);
      we        = N'($urandom);
      addr      = (N*16)'({$urandom(), $urandom()});
      wdata     = (N*16)'({$urandom(), $urandom()});
      mem_rdata = 16'($urandom);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
